// File: rtl/ni_vc_wb_cfg_master.sv
// ni_vc_wb_cfg_master
// Wishbone master that programs the NI VC register bank for a local engine.
// A send request becomes three writes (size, start address, destination);
// a receive-arm request becomes three writes (max size, start address, control).
// The destination / control write is last because it is what kicks the NI.
module ni_vc_wb_cfg_master #(
    parameter int Dw                    = 32,
    parameter int S_Aw                  = 4,
    parameter int MAX_TRANSACTION_WIDTH = 10,
    parameter int DST_ADR_HDR_WIDTH     = 8,
    parameter int NX                    = 4,
    parameter int NY                    = 4,
    parameter int C                     = 4,
    parameter int TIMEOUT_CYCLES        = 255,
    localparam int MTW  = MAX_TRANSACTION_WIDTH,
    localparam int Xw   = (NX > 1) ? $clog2(NX) : 1,
    localparam int Yw   = (NY > 1) ? $clog2(NY) : 1,
    localparam int Cw   = (C > 1) ? $clog2(C) : 1,
    localparam int SELw = Dw / 8
) (
    input  logic            clk,
    input  logic            reset,
    // command side
    input  logic            send_req,
    input  logic [Dw-1:0]   send_addr,
    input  logic [MTW-1:0]  send_size,
    input  logic [Xw-1:0]   send_dest_x,
    input  logic [Yw-1:0]   send_dest_y,
    input  logic [Cw-1:0]   send_class,
    input  logic            recv_req,
    input  logic [Dw-1:0]   recv_addr,
    input  logic [MTW-1:0]  recv_buf_size,
    output logic            send_accept,
    output logic            recv_accept,
    output logic            busy,
    output logic            done,
    output logic            error,
    // wishbone master side
    output logic [Dw-1:0]   m_dat_o,
    output logic [S_Aw-1:0] m_addr_o,
    output logic [SELw-1:0] m_sel_o,
    output logic            m_stb_o,
    output logic            m_cyc_o,
    output logic            m_we_o,
    input  logic            m_ack_i,
    input  logic            m_err_i
);

    localparam int OFFSET_w = (SELw > 1) ? $clog2(SELw) : 0;

    // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    // NI register word addresses
    localparam logic [S_Aw-1:0] A_SEND_SIZE = S_Aw'(3);
    localparam logic [S_Aw-1:0] A_SEND_STRT = S_Aw'(4);
    localparam logic [S_Aw-1:0] A_SEND_DEST = S_Aw'(5);
    localparam logic [S_Aw-1:0] A_RECV_STRT = S_Aw'(8);
    localparam logic [S_Aw-1:0] A_RECV_CTRL = S_Aw'(10);
    localparam logic [S_Aw-1:0] A_RECV_MAX  = S_Aw'(11);

    typedef enum logic [2:0] {
        IDLE,
        S_SIZE,
        S_STRT,
        S_DEST,
        R_MAX,
        R_STRT,
        R_CTRL
    } state_t;

    // Request fields captured at accept; send and receive share addr/size.
    typedef struct packed {
        logic [Dw-1:0]  addr;
        logic [MTW-1:0] size;
        logic [Xw-1:0]  x;
        logic [Yw-1:0]  y;
        logic [Cw-1:0]  cls;
    } req_t;

    state_t          state, state_nxt;
    req_t            req_q;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic            load_send, load_recv;
    logic            fin, abort;

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: IDLE arbitration (recv first), write sequencing, abort on err/timeout
    always_comb begin
        state_nxt = state;
        load_send = 1'b0;
        load_recv = 1'b0;
        fin       = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (recv_req) begin
                    state_nxt = R_MAX;
                    load_recv = 1'b1;
                end else if (send_req) begin
                    state_nxt = S_SIZE;
                    load_send = 1'b1;
                end
            end
            default: begin
                if (m_err_i || (!m_ack_i && tmo_hit)) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (m_ack_i) begin
                    case (state)
                        S_SIZE:  state_nxt = S_STRT;
                        S_STRT:  state_nxt = S_DEST;
                        S_DEST:  begin state_nxt = IDLE; fin = 1'b1; end
                        R_MAX:   state_nxt = R_STRT;
                        R_STRT:  state_nxt = R_CTRL;
                        R_CTRL:  begin state_nxt = IDLE; fin = 1'b1; end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
        endcase
    end

    // Capture the winning request; later input changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q <= '0;
        end else if (load_recv) begin
            req_q.addr <= recv_addr;
            req_q.size <= recv_buf_size;
            req_q.x    <= '0;
            req_q.y    <= '0;
            req_q.cls  <= '0;
        end else if (load_send) begin
            req_q.addr <= send_addr;
            req_q.size <= send_size;
            req_q.x    <= send_dest_x;
            req_q.y    <= send_dest_y;
            req_q.cls  <= send_class;
        end
    end

    // Per-write ack timeout; restarts whenever a new write is presented
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state == IDLE || state_nxt != state)
            tmo_cnt <= '0;
        else if (TIMEOUT_CYCLES != 0)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Single-cycle status pulses, one cycle after the deciding edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            send_accept <= 1'b0;
            recv_accept <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            send_accept <= load_send;
            recv_accept <= load_recv;
            done        <= fin;
            error       <= abort;
        end
    end

    // Bus controls follow state: cyc held across the whole sequence
    always_comb begin
        busy    = (state != IDLE);
        m_stb_o = busy;
        m_cyc_o = busy;
        m_we_o  = busy;
        m_sel_o = {SELw{busy}};
    end

    // Register address and write data for the current write
    always_comb begin
        m_addr_o = '0;
        m_dat_o  = '0;
        case (state)
            S_SIZE: begin
                m_addr_o = A_SEND_SIZE;
                m_dat_o  = Dw'(req_q.size) << OFFSET_w;
            end
            S_STRT: begin
                m_addr_o = A_SEND_STRT;
                m_dat_o  = req_q.addr << OFFSET_w;
            end
            S_DEST: begin
                m_addr_o = A_SEND_DEST;
                m_dat_o[Xw-1:0]                       = req_q.x;
                m_dat_o[DST_ADR_HDR_WIDTH/2 +: Yw]    = req_q.y;
                m_dat_o[DST_ADR_HDR_WIDTH +: Cw]      = req_q.cls;
            end
            R_MAX: begin
                m_addr_o = A_RECV_MAX;
                m_dat_o[MTW-1:0] = req_q.size;
            end
            R_STRT: begin
                m_addr_o = A_RECV_STRT;
                m_dat_o  = req_q.addr << OFFSET_w;
            end
            R_CTRL: begin
                m_addr_o = A_RECV_CTRL;
                m_dat_o  = Dw'(1);
            end
            default: begin
                m_addr_o = '0;
                m_dat_o  = '0;
            end
        endcase
    end

endmodule
